// File: rtl/encryption_ctrl.sv
// -----------------------------------------------------------------------------
// encryption_ctrl
//   Control FSM for an iterative AES-128 style datapath. A start request loads
//   the plaintext together with round key 0 (INIT_ROUND). It then runs rounds
//   1..9 (MID_ROUND) and round 10 (FINAL_ROUND, without MixColumns). Each round
//   takes three phases, counted down by cyc = 2,1,0:
//     cyc=2 : request the round key for round_idx
//     cyc=1 : round function settles
//     cyc=0 : write the round result back into the state register
//   Without stalls, done pulses 32 cycles after start is sampled in IDLE.
//
// Configuration macro:
//   ENC_KEY_HANDSHAKE_EN - when defined, phase cyc=2 holds (req_key stays high)
//                          until key_valid=1. When undefined, key_valid is
//                          ignored and the latency is fixed.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin an encryption (accepted in IDLE only)
//   key_valid  in   requested round key available (handshake build only)
//   mux_sel    out  state-register source: 0 = plaintext, 1 = round feedback
//   state_we   out  state-register write enable
//   round_idx  out  round-key index 0..10
//   req_key    out  round-key request for round_idx
//   last_round out  final round (datapath skips MixColumns)
//   busy       out  operation in progress (every state except IDLE)
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module encryption_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    output logic       mux_sel,
    output logic       state_we,
    output logic [3:0] round_idx,
    output logic       req_key,
    output logic       last_round,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT_ROUND,
        MID_ROUND,
        FINAL_ROUND,
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] cyc_reg, cyc_next;
    logic [3:0] round_reg, round_next;
    logic       key_ok;
    logic       in_round;

`ifdef ENC_KEY_HANDSHAKE_EN
    assign key_ok = key_valid;
`else
    // Key is assumed to be ready in the same cycle it is requested.
    logic unused_key_valid;
    assign unused_key_valid = key_valid;
    assign key_ok           = 1'b1;
`endif

    assign in_round = (state_reg == MID_ROUND) || (state_reg == FINAL_ROUND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cyc_reg   <= 2'd0;
            round_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                cyc_next   = 2'd0;
                round_next = 4'd0;
                if (start) begin
                    state_next = INIT_ROUND;
                end
            end
            INIT_ROUND: begin
                state_next = MID_ROUND;
                round_next = 4'd1;
                cyc_next   = 2'd2;
            end
            MID_ROUND, FINAL_ROUND: begin
                case (cyc_reg)
                    2'd2: begin
                        // Hold in the key-request phase until the key arrives.
                        if (key_ok) begin
                            cyc_next = 2'd1;
                        end
                    end
                    2'd1: begin
                        cyc_next = 2'd0;
                    end
                    2'd0: begin
                        if (state_reg == FINAL_ROUND) begin
                            state_next = DONE;
                            round_next = 4'd0;
                            cyc_next   = 2'd0;
                        end else if (round_reg >= 4'd9) begin
                            state_next = FINAL_ROUND;
                            round_next = 4'd10;
                            cyc_next   = 2'd2;
                        end else begin
                            round_next = round_reg + 4'd1;
                            cyc_next   = 2'd2;
                        end
                    end
                    default: begin
                        // cyc=3 is unreachable; fold it into the write phase.
                        cyc_next = 2'd0;
                    end
                endcase
            end
            DONE: begin
                // start is deliberately ignored here; a new operation must be
                // requested from IDLE.
                state_next = IDLE;
                cyc_next   = 2'd0;
                round_next = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cyc_next   = 2'd0;
                round_next = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    assign mux_sel    = in_round;
    assign state_we   = (state_reg == INIT_ROUND) || (in_round && (cyc_reg == 2'd0));
    assign req_key    = in_round && (cyc_reg == 2'd2);
    assign last_round = (state_reg == FINAL_ROUND);
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign round_idx  = round_reg;

endmodule

// File: tb/tb_encryption_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encryption_ctrl
//   Scoreboard bench for encryption_ctrl. Stimulus pushes one expected record
//   per accepted start (done cycle, state_we / req_key / last_round counts);
//   a monitor accumulates per-operation activity and checks it when done
//   pulses.
// -----------------------------------------------------------------------------
module tb_encryption_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       key_valid;
    logic       mux_sel;
    logic       state_we;
    logic [3:0] round_idx;
    logic       req_key;
    logic       last_round;
    logic       busy;
    logic       done;

    encryption_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_valid  (key_valid),
        .mux_sel    (mux_sel),
        .state_we   (state_we),
        .round_idx  (round_idx),
        .req_key    (req_key),
        .last_round (last_round),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int done_cycle;
        int we;
        int req;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   stall_left = 0;

    // Monitor per-operation accumulators
    int we_cnt   = 0;
    int req_cnt  = 0;
    int last_cnt = 0;
    int max_idx  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Key expander model: withhold the key for stall_left cycles of round 5.
    always @(negedge clk) begin
        if (req_key && round_idx == 4'd5 && stall_left > 0) begin
            key_valid = 1'b0;
            stall_left--;
        end else begin
            key_valid = 1'b1;
        end
    end

    // Monitor: samples on the falling edge, stimulus changes at falling edge + 1.
    always @(negedge clk) begin
        if (!busy) begin
            we_cnt = 0; req_cnt = 0; last_cnt = 0; max_idx = 0;
        end else begin
            if (int'(round_idx) > max_idx) max_idx = int'(round_idx);
            if (state_we) begin
                chk("we_round_idx", int'(round_idx), we_cnt);
                we_cnt++;
            end
            if (req_key) req_cnt++;
            if (last_round) begin
                chk("last_round_idx", int'(round_idx), 10);
                last_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("done at cycle %0d (exp %0d) we=%0d req=%0d last=%0d",
                             cycle, e.done_cycle, we_cnt, req_cnt, last_cnt);
                    chk("done_cycle", cycle, e.done_cycle);
                    chk("we_count", we_cnt, e.we);
                    chk("req_count", req_cnt, e.req);
                    chk("last_count", last_cnt, e.last);
                    chk("max_round_idx", max_idx, 10);
                    chk("done_round_idx", int'(round_idx), 0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int lat, input int req);
        exp_t e;
        e.done_cycle = cycle + lat;
        e.we         = 11;
        e.req        = req;
        e.last       = 3;
        exp_q.push_back(e);
    endtask

    task automatic issue(input int lat, input int req);
        step();
        start = 1'b1;
        push_exp(lat, req);
        step();
        start = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            chk("drain_timeout", 1, 0);
            exp_q.delete();
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_mux_sel"}, int'(mux_sel), 0);
        chk({tag, "_state_we"}, int'(state_we), 0);
        chk({tag, "_req_key"}, int'(req_key), 0);
        chk({tag, "_last_round"}, int'(last_round), 0);
        chk({tag, "_round_idx"}, int'(round_idx), 0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        key_valid = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk_idle_outputs("reset");

        // Plain run: done 32 cycles after start, 11 writes, 10 key requests.
        issue(32, 10);
        wait_drained(60);

        // Key stall in round 5 (only effective in the handshake build).
        stall_left = 4;
`ifdef ENC_KEY_HANDSHAKE_EN
        issue(36, 14);
`else
        issue(32, 10);
`endif
        wait_drained(60);
        stall_left = 0;

        // start held high: restarts only from IDLE, one done every 33 cycles.
        step();
        start = 1'b1;
        push_exp(32, 10);
        push_exp(65, 10);
        push_exp(98, 10);
        repeat (98) step();
        chk("held_third_done", int'(done), 1);
        start = 1'b0;
        wait_drained(20);

        // start during DONE is ignored.
        issue(32, 10);
        n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        chk("done_seen", int'(done), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_done_busy", int'(busy), 0);
        chk("start_in_done_idx", int'(round_idx), 0);
        repeat (3) step();
        chk("start_in_done_stay_idle", int'(busy), 0);

        // Reset at round 6, phase cyc=1.
        issue(32, 10);
        n = 0;
        while (!(req_key && round_idx == 4'd6) && n < 60) begin
            step();
            n++;
        end
        chk("round6_reached", int'(req_key && round_idx == 4'd6), 1);
        step();
        chk("round6_cyc1_busy", int'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        chk_idle_outputs("mid_reset");
        issue(32, 10);
        wait_drained(60);

        // Reset wins over a simultaneous start.
        step();
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_prio_busy", int'(busy), 0);
        step();
        chk("reset_prio_stay_idle", int'(busy), 0);

        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/encryption_ctrl.md
ENCRYPTION_CTRL -- requirements
Module: encryption_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-003 The block SHALL have port start, input, 1, request to encrypt the block presented on the datapath input.
REQ-004 The block SHALL have port key_valid, input, 1, key expander indicates the requested round key is available (used only when ENC_KEY_HANDSHAKE_EN is defined).
REQ-005 The block SHALL have port mux_sel, output, 1, datapath state-register source: 0 = plaintext input, 1 = round-function feedback.
REQ-006 The block SHALL have port state_we, output, 1, datapath state-register write enable.
REQ-007 The block SHALL have port round_idx, output, 4, round-key index 0..10, ascending.
REQ-008 The block SHALL have port req_key, output, 1, round-key request for round_idx.
REQ-009 The block SHALL have port last_round, output, 1, datapath skips MixColumns.
REQ-010 The block SHALL have ports busy, output, 1, operation in progress, and done, output, 1, one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, INIT_ROUND, MID_ROUND, FINAL_ROUND, DONE plus a 2-bit phase counter cyc and a 4-bit round counter.
REQ-012 In IDLE with start=1, next state SHALL be INIT_ROUND with round_idx=0; start=0 keeps IDLE.
REQ-013 INIT_ROUND SHALL last one cycle with mux_sel=0, state_we=1, round_idx=0 (plaintext load plus AddRoundKey 0), then go to MID_ROUND with round_idx=1, cyc=2.
REQ-014 Each MID_ROUND or FINAL_ROUND round SHALL step through phases cyc=2,1,0 with mux_sel=1 throughout.
REQ-015 req_key SHALL be 1 exactly while cyc=2 in MID_ROUND or FINAL_ROUND, else 0.
REQ-016 state_we SHALL be 1 only in INIT_ROUND and at cyc=0 of MID_ROUND or FINAL_ROUND.
REQ-017 At cyc=0 in MID_ROUND: round_idx<9 SHALL increment round_idx with cyc=2; round_idx=9 SHALL go to FINAL_ROUND with round_idx=10, cyc=2.
REQ-018 last_round SHALL be 1 throughout FINAL_ROUND only.
REQ-019 At cyc=0 in FINAL_ROUND the FSM SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE; done and busy both 1 in DONE.
REQ-021 start while busy=1, including in DONE, SHALL be ignored; back-to-back operation requires start sampled in IDLE.
REQ-022 Without stalls, done SHALL assert 32 cycles after the cycle in which start is sampled in IDLE.
REQ-023 round_idx SHALL never exceed 10 and SHALL hold 0 in IDLE and DONE.

Reset
REQ-024 reset=1 SHALL, on the next rising edge, force IDLE, cyc=0, round_idx=0, regardless of current state, including mid-round or during a key stall.
REQ-025 After reset, the outputs mux_sel, state_we, req_key, last_round, busy and done SHALL all be 0.
REQ-026 reset SHALL take priority over start asserted in the same cycle.

Configuration
REQ-027 Macro ENC_KEY_HANDSHAKE_EN SHALL be defined: at cyc=2 with key_valid=0 the FSM SHALL hold state, cyc, round_idx with req_key held 1, advancing only on key_valid=1.
REQ-028 Macro ENC_KEY_HANDSHAKE_EN SHALL be undefined: key_valid SHALL be ignored, cyc=2 SHALL always last one cycle, and latency SHALL be fixed at 32.

Verification
REQ-029 Reset, then start pulse, no stalls -> done exactly 32 cycles after start; state_we pulses 11 times; round_idx sequence 0,1..10.
REQ-030 Observe last_round during the run -> 1 only for 3 cycles with round_idx=10; req_key 10 pulses, one per round 1..10.
REQ-031 ENC_KEY_HANDSHAKE_EN defined, key_valid low 4 cycles in round 5 -> req_key high 5 cycles, done at 36.
REQ-032 start held high continuously -> operations restart only from IDLE; done pulses every 33 cycles.
REQ-033 reset asserted at round_idx=6, cyc=1 -> next cycle IDLE, busy=0, round_idx=0; subsequent start gives done at 32.
REQ-034 start asserted in DONE cycle -> ignored; FSM returns to IDLE, busy=0.
